// File: rtl/arp_tx.sv
// arp_tx: builds and streams a complete Ethernet II ARP frame, one byte per clock.
// The frame is preamble, SFD, Ethernet header, ARP body, zero padding and FCS,
// followed by an enforced inter-frame gap.
// Ports:
//   arp_tx_clk   - byte clock
//   rstn         - asynchronous active-low reset
//   arp_tx_en    - start request, sampled only while idle
//   arp_tx_type  - 1 = ARP request (op 1), 0 = ARP reply (op 2)
//   des_mac      - target MAC (reply only)
//   des_ip       - target IP
//   arp_tx_valid - arp_tx_data carries a frame byte
//   arp_tx_data  - frame byte
//   arp_tx_busy  - high from accept until the inter-frame gap has elapsed
//   arp_tx_done  - one-cycle pulse with the last FCS byte
module arp_tx #(
  parameter logic [47:0] FPGA_MAC   = 48'h00_11_22_33_44_55,
  parameter logic [31:0] FPGA_IP    = 32'hc0_a8_00_03,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        arp_tx_clk,
  input  logic        rstn,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        arp_tx_valid,
  output logic [7:0]  arp_tx_data,
  output logic        arp_tx_busy,
  output logic        arp_tx_done
);

  localparam int unsigned HDR_W = 336;  // frame bytes 8..49
  localparam int unsigned CNT_W = 7;
  localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_ETH_HEAD, S_ARP_BODY, S_PAD, S_CRC, S_IFG
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_byte_q, cnt_byte_d;
  logic [IFG_W-1:0]   ifg_q, ifg_d;
  logic [31:0]        crc_q, crc_d;
  logic               type_q, type_d;
  logic [47:0]        mac_q, mac_d;
  logic [31:0]        ip_q, ip_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [HDR_W-1:0]   hdr_c;
  logic [5:0]         hdr_idx_c;
  logic [7:0]         hdr_byte_c;

  // Reflected CRC32 (0xEDB88320) update by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Header + ARP body from the latched request; byte 8 sits in the top byte.
  always_comb begin
    hdr_c = {type_q ? 48'hFFFF_FFFF_FFFF : mac_q,
             FPGA_MAC, 16'h0806,
             16'h0001, 16'h0800, 8'h06, 8'h04,
             type_q ? 16'h0001 : 16'h0002,
             FPGA_MAC, FPGA_IP,
             type_q ? 48'h0 : mac_q,
             ip_q};
    hdr_idx_c  = 6'(7'd49 - cnt_byte_q);
    hdr_byte_c = 8'(hdr_c >> {hdr_idx_c, 3'b000});
  end

  // State and output registers.
  always_ff @(posedge arp_tx_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_byte_q <= '0;
      ifg_q      <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      type_q     <= 1'b0;
      mac_q      <= '0;
      ip_q       <= '0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_byte_q <= cnt_byte_d;
      ifg_q      <= ifg_d;
      crc_q      <= crc_d;
      type_q     <= type_d;
      mac_q      <= mac_d;
      ip_q       <= ip_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state: each non-idle state registers byte cnt_byte_q on the next edge.
  always_comb begin
    state_d    = state_q;
    cnt_byte_d = cnt_byte_q;
    ifg_d      = ifg_q;
    crc_d      = crc_q;
    type_d     = type_q;
    mac_d      = mac_q;
    ip_d       = ip_q;
    valid_d    = 1'b0;
    data_d     = 8'h00;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_byte_d = '0;
        if (arp_tx_en) begin
          type_d  = arp_tx_type;
          mac_d   = des_mac;
          ip_d    = des_ip;
          busy_d  = 1'b1;
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        valid_d    = 1'b1;
        data_d     = 8'h55;
        cnt_byte_d = cnt_byte_q + 1'b1;
        if (cnt_byte_q == 7'd6) state_d = S_SFD;
      end
      S_SFD: begin
        valid_d    = 1'b1;
        data_d     = 8'hD5;
        crc_d      = 32'hFFFF_FFFF;
        cnt_byte_d = cnt_byte_q + 1'b1;
        state_d    = S_ETH_HEAD;
      end
      S_ETH_HEAD, S_ARP_BODY: begin
        valid_d    = 1'b1;
        data_d     = hdr_byte_c;
        crc_d      = crc32_byte(crc_q, hdr_byte_c);
        cnt_byte_d = cnt_byte_q + 1'b1;
        if (state_q == S_ETH_HEAD && cnt_byte_q == 7'd21) state_d = S_ARP_BODY;
        if (state_q == S_ARP_BODY && cnt_byte_q == 7'd49) state_d = S_PAD;
      end
      S_PAD: begin
        valid_d    = 1'b1;
        data_d     = 8'h00;
        crc_d      = crc32_byte(crc_q, 8'h00);
        cnt_byte_d = cnt_byte_q + 1'b1;
        if (cnt_byte_q == 7'd67) state_d = S_CRC;
      end
      S_CRC: begin
        // FCS goes out inverted, least-significant byte first (byte 68 = bits 7:0).
        valid_d = 1'b1;
        data_d  = 8'(~crc_q >> {cnt_byte_q[1:0], 3'b000});
        if (cnt_byte_q == 7'd71) begin
          done_d  = 1'b1;
          ifg_d   = '0;
          state_d = S_IFG;
        end else begin
          cnt_byte_d = cnt_byte_q + 1'b1;
        end
      end
      S_IFG: begin
        ifg_d = ifg_q + 1'b1;
        if (ifg_q == IFG_W'(IFG_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign arp_tx_valid = valid_q;
  assign arp_tx_data  = data_q;
  assign arp_tx_busy  = busy_q;
  assign arp_tx_done  = done_q;

endmodule
